// File: rtl/bp_update_scheduler.sv
// Branch predictor table write sequencer: queues branch resolutions, drains them as
// read-modify-write updates, and runs full-table clear sweeps. Optional BP_STATS_EN adds counters.
module bp_update_scheduler #(
    parameter int WORD_SIZE  = 16,
    parameter int INDEX_BIT  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           res_valid,
    output logic                           res_ready,
    input  logic [WORD_SIZE-1:0]           res_pc,
    input  logic [WORD_SIZE-1:0]           res_target,
    input  logic                           res_taken,
    input  logic                           res_pred,
    input  logic                           clr_req,
    output logic                           clr_done,
    output logic                           mispredict,
    output logic [INDEX_BIT-1:0]           rd_index,
    input  logic [WORD_SIZE-INDEX_BIT-1:0] rd_tag,
    input  logic                           rd_valid,
    input  logic [1:0]                     rd_state,
    output logic                           wr_en,
    output logic [INDEX_BIT-1:0]           wr_index,
    output logic [WORD_SIZE-INDEX_BIT-1:0] wr_tag,
    output logic [WORD_SIZE-1:0]           wr_target,
    output logic [1:0]                     wr_state,
    output logic                           wr_valid,
    output logic                           busy
`ifdef BP_STATS_EN
    ,
    output logic [15:0]                    stat_branches,
    output logic [15:0]                    stat_mispred
`endif
);

    localparam int TAG_W = WORD_SIZE - INDEX_BIT;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]     FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [INDEX_BIT-1:0] LAST_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_UPDATE,
        ST_CLEAR
    } state_t;

    function automatic logic [1:0] sat_inc(input logic [1:0] s);
        return (s == 2'd3) ? 2'd3 : s + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] s);
        return (s == 2'd0) ? 2'd0 : s - 2'd1;
    endfunction

`ifdef BP_STATS_EN
    function automatic logic [15:0] sat_cnt(input logic [15:0] c, input logic inc);
        return (inc && c != 16'hFFFF) ? c + 16'd1 : c;
    endfunction
`endif

    state_t state, state_nxt;

    logic [WORD_SIZE-1:0] fifo_pc     [FIFO_DEPTH];
    logic [WORD_SIZE-1:0] fifo_target [FIFO_DEPTH];
    logic                 fifo_taken  [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count, count_nxt;
    logic                 fifo_empty, fifo_full;
    logic                 push, pop;
    logic                 mis_p0;

    logic [WORD_SIZE-1:0] head_pc, head_target;
    logic                 head_taken;
    logic [TAG_W-1:0]     head_tag;
    logic [INDEX_BIT-1:0] head_idx;
    logic                 hit;

    logic [INDEX_BIT-1:0] clr_idx;

    // Acceptance stage: handshake and queue bookkeeping
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == FULL_CNT);
    assign res_ready  = ~fifo_full;
    assign push       = res_valid & ~fifo_full;
    // A clear request in UPDATE holds the head entry so it is applied after the sweep
    assign pop        = (state == ST_UPDATE) & ~fifo_empty & ~clr_req;
    assign mis_p0     = push & (res_pred != res_taken);
    assign count_nxt  = count + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]     <= res_pc;
            fifo_target[wr_ptr] <= res_target;
            fifo_taken[wr_ptr]  <= res_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            mispredict <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count      <= count_nxt;
            mispredict <= mis_p0;
        end
    end

    // Lookup stage: head entry drives the table read port
    assign head_pc     = fifo_pc[rd_ptr];
    assign head_target = fifo_target[rd_ptr];
    assign head_taken  = fifo_taken[rd_ptr];
    assign head_tag    = head_pc[WORD_SIZE-1:INDEX_BIT];
    assign head_idx    = head_pc[INDEX_BIT-1:0];
    assign rd_index    = fifo_empty ? '0 : head_idx;
    assign hit         = rd_valid & (rd_tag == head_tag);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            clr_idx  <= '0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            clr_done <= (state == ST_CLEAR) && (clr_idx == LAST_IDX);
            if (state == ST_CLEAR) clr_idx <= clr_idx + INDEX_BIT'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (clr_req)          state_nxt = ST_CLEAR;
                else if (!fifo_empty) state_nxt = ST_UPDATE;
            end
            ST_UPDATE: begin
                if (clr_req)                state_nxt = ST_CLEAR;
                else if (count_nxt == '0)   state_nxt = ST_IDLE;
            end
            ST_CLEAR: begin
                if (clr_idx == LAST_IDX)    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Write stage: table write port, valid the same cycle the entry pops
    always_comb begin
        wr_en     = 1'b0;
        wr_index  = '0;
        wr_tag    = '0;
        wr_target = '0;
        wr_state  = 2'd0;
        wr_valid  = 1'b0;
        case (state)
            ST_UPDATE: begin
                if (pop && (hit || head_taken)) begin
                    wr_en     = 1'b1;
                    wr_index  = head_idx;
                    wr_tag    = head_tag;
                    // Direct branches resolve to the stored target on a hit, so rewriting it is safe
                    wr_target = head_target;
                    wr_valid  = 1'b1;
                    if (!hit)           wr_state = 2'd2;
                    else if (head_taken) wr_state = sat_inc(rd_state);
                    else                wr_state = sat_dec(rd_state);
                end
            end
            ST_CLEAR: begin
                wr_en    = 1'b1;
                wr_index = clr_idx;
            end
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

`ifdef BP_STATS_EN
    // Clearing on clr_done still counts an event accepted in that same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stat_branches <= '0;
            stat_mispred  <= '0;
        end else begin
            stat_branches <= sat_cnt(clr_done ? 16'h0 : stat_branches, push);
            stat_mispred  <= sat_cnt(clr_done ? 16'h0 : stat_mispred, mis_p0);
        end
    end
`endif

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Directed bench for bp_update_scheduler with a behavioural predictor table on the rd_/wr_ ports.
module tb_bp_update_scheduler;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        res_valid, res_ready;
    logic [15:0] res_pc, res_target;
    logic        res_taken, res_pred;
    logic        clr_req, clr_done, mispredict;
    logic [3:0]  rd_index;
    logic [11:0] rd_tag;
    logic        rd_valid;
    logic [1:0]  rd_state;
    logic        wr_en;
    logic [3:0]  wr_index;
    logic [11:0] wr_tag;
    logic [15:0] wr_target;
    logic [1:0]  wr_state;
    logic        wr_valid;
    logic        busy;
`ifdef BP_STATS_EN
    logic [15:0] stat_branches, stat_mispred;
    logic [15:0] mis_before;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic        force_miss;
    logic        tbl_valid [16];
    logic [11:0] tbl_tag   [16];
    logic [1:0]  tbl_state [16];

    always #5 clk = ~clk;

    bp_update_scheduler dut (
        .clk(clk), .reset_n(reset_n),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_pc(res_pc), .res_target(res_target),
        .res_taken(res_taken), .res_pred(res_pred),
        .clr_req(clr_req), .clr_done(clr_done), .mispredict(mispredict),
        .rd_index(rd_index), .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_state(rd_state),
        .wr_en(wr_en), .wr_index(wr_index), .wr_tag(wr_tag), .wr_target(wr_target),
        .wr_state(wr_state), .wr_valid(wr_valid), .busy(busy)
`ifdef BP_STATS_EN
        , .stat_branches(stat_branches), .stat_mispred(stat_mispred)
`endif
    );

    // Table storage: written on posedge, read combinationally
    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 16; i++) begin
                tbl_valid[i] <= 1'b0;
                tbl_tag[i]   <= '0;
                tbl_state[i] <= '0;
            end
        end else if (wr_en) begin
            tbl_valid[wr_index] <= wr_valid;
            tbl_tag[wr_index]   <= wr_tag;
            tbl_state[wr_index] <= wr_state;
        end
    end

    always_comb begin
        rd_tag   = tbl_tag[rd_index];
        rd_valid = tbl_valid[rd_index] & ~force_miss;
        rd_state = tbl_state[rd_index];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_evt(input logic [15:0] pc, input logic [15:0] tgt,
                            input logic tk, input logic pr);
        res_valid  = 1'b1;
        res_pc     = pc;
        res_target = tgt;
        res_taken  = tk;
        res_pred   = pr;
        tick();
        res_valid  = 1'b0;
    endtask

    task automatic expect_wr(input string nm, input logic [3:0] idx, input logic [11:0] tg,
                             input logic [15:0] tgt, input logic [1:0] st);
        check({nm, "_en"},    wr_en,     1);
        check({nm, "_idx"},   wr_index,  idx);
        check({nm, "_tag"},   wr_tag,    tg);
        check({nm, "_tgt"},   wr_target, tgt);
        check({nm, "_state"}, wr_state,  st);
        check({nm, "_valid"}, wr_valid,  1);
    endtask

    // One event through an idle scheduler: accept, update cycle, back to idle
    task automatic one_update(input string nm, input logic [15:0] pc, input logic [15:0] tgt,
                              input logic tk, input logic pr, input logic exp_wr,
                              input logic [1:0] st);
        logic [3:0]  idx;
        logic [11:0] tg;
        idx = pc[3:0];
        tg  = pc[15:4];
        push_evt(pc, tgt, tk, pr);
        tick();
        check({nm, "_busy"}, busy, 1);
        if (exp_wr) expect_wr(nm, idx, tg, tgt, st);
        else        check({nm, "_nowr"}, wr_en, 0);
        tick();
        check({nm, "_idle"}, busy, 0);
    endtask

    initial begin
        reset_n    = 1'b0;
        res_valid  = 1'b0;
        res_pc     = '0;
        res_target = '0;
        res_taken  = 1'b0;
        res_pred   = 1'b0;
        clr_req    = 1'b0;
        force_miss = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        check("rst_wr_en",     wr_en,      0);
        check("rst_busy",      busy,       0);
        check("rst_ready",     res_ready,  1);
        check("rst_clr_done",  clr_done,   0);
        check("rst_mispred",   mispredict, 0);
        check("rst_wr_index",  wr_index,   0);
        check("rst_wr_tag",    wr_tag,     0);
        check("rst_wr_target", wr_target,  0);
        check("rst_wr_state",  wr_state,   0);
        check("rst_wr_valid",  wr_valid,   0);
        reset_n = 1'b1;
        tick();
        check("post_rst_busy", busy, 0);

        // Allocate on a taken miss, then saturate upward
        one_update("alloc", 16'h0023, 16'h0040, 1'b1, 1'b1, 1'b1, 2'd2);
        check("alloc_mispred", mispredict, 0);
        one_update("inc1",  16'h0023, 16'h0040, 1'b1, 1'b1, 1'b1, 2'd3);
        one_update("inc2",  16'h0023, 16'h0040, 1'b1, 1'b1, 1'b1, 2'd3);

        // First not-taken is a mispredict (pred=1)
`ifdef BP_STATS_EN
        mis_before = stat_mispred;
`endif
        push_evt(16'h0023, 16'h0040, 1'b0, 1'b1);
        check("mis_pulse", mispredict, 1);
`ifdef BP_STATS_EN
        check("stat_mis_inc", stat_mispred, mis_before + 16'd1);
`endif
        tick();
        check("mis_drop", mispredict, 0);
        expect_wr("dec1", 4'h3, 12'h002, 16'h0040, 2'd2);
        tick();
        check("dec1_idle", busy, 0);
        one_update("dec2", 16'h0023, 16'h0040, 1'b0, 1'b0, 1'b1, 2'd1);
        one_update("dec3", 16'h0023, 16'h0040, 1'b0, 1'b0, 1'b1, 2'd0);
        one_update("dec4", 16'h0023, 16'h0040, 1'b0, 1'b0, 1'b1, 2'd0);

        // Not-taken miss: popped without a write
        one_update("miss_nt", 16'h0105, 16'h0000, 1'b0, 1'b0, 1'b0, 2'd0);

        // Fill the queue while a clear sweep stalls draining
        clr_req = 1'b1;
        tick();
        check("clr_busy", busy, 1);
        clr_req    = 1'b0;
        force_miss = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check("clr_en",    wr_en,    1);
            check("clr_idx",   wr_index, k);
            check("clr_valid", wr_valid, 0);
            check("clr_state", wr_state, 0);
            if (k < 5) begin
                check("fill_ready", res_ready, (k < 4) ? 1 : 0);
                res_valid  = 1'b1;
                res_pc     = 16'h0A01 + 16'(k);
                res_target = 16'h1000 + 16'(k);
                res_taken  = 1'b1;
                res_pred   = (k < 4);
            end else begin
                res_valid = 1'b0;
            end
            tick();
            if (k == 4) check("full_no_mis", mispredict, 0);
        end
        check("clr_done_pulse", clr_done, 1);
        check("clr_done_idle",  busy,     0);
        check("clr_done_nowr",  wr_en,    0);
        tick();
        check("clr_done_drop", clr_done, 0);
        for (int i = 0; i < 4; i++) begin
            expect_wr("drain", 4'(i + 1), 12'h0A0, 16'h1000 + 16'(i), 2'd2);
            tick();
        end
        check("drain_only4", busy, 0);
        check("drain_nowr",  wr_en, 0);
        force_miss = 1'b0;

        // Clear request arrives while two entries are queued in UPDATE
        push_evt(16'h0031, 16'h0050, 1'b1, 1'b1);
        push_evt(16'h0032, 16'h0060, 1'b1, 1'b1);
        check("upd_busy", busy, 1);
        clr_req = 1'b1;
        #1;
        check("upd_hold_nowr", wr_en, 0);
        tick();
        clr_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            check("clr2_en",  wr_en,    1);
            check("clr2_idx", wr_index, k);
            tick();
        end
        check("clr2_done", clr_done, 1);
        tick();
        expect_wr("post_clr_a", 4'h1, 12'h003, 16'h0050, 2'd2);
        tick();
        expect_wr("post_clr_b", 4'h2, 12'h003, 16'h0060, 2'd2);
        tick();
        check("post_clr_idle", busy, 0);

        // Reset during a sweep with one event queued
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        push_evt(16'h0044, 16'h0000, 1'b1, 1'b1);
        reset_n = 1'b0;
        tick();
        check("rst2_busy",  busy,      0);
        check("rst2_wr_en", wr_en,     0);
        check("rst2_ready", res_ready, 1);
        reset_n = 1'b1;
        tick();
        check("rst2_flushed", busy, 0);
        tick();
        check("rst2_still_idle", busy,  0);
        check("rst2_no_wr",      wr_en, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
